ucode_sequencer: RTL and testbench

- Upstream neighbour of the control-word decoder: accepts 16-bit instructions from fetch and steps through a synchronous microcode ROM.
- Emits one 32-bit control word per micro-op, with instruction register fields substituted in, on a valid/stall interface.
- Provides dispatch, micro-PC sequencing, back-to-back instruction chaining, flush and sequence-overrun detection.

---
 rtl/ucode_sequencer.sv | 141 ++++++++++++++
 tb/tb_ucode_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: dispatches 16-bit instructions into a synchronous
// microcode ROM, steps the micro-PC and emits one substituted control word
// per micro-op on a valid/stall interface.
module ucode_sequencer #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned UADDR_W = 7,
  parameter int unsigned SLOT_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               stall,
  input  logic               flush,
  output logic [UADDR_W-1:0] ucode_addr,
  output logic               ucode_en,
  input  logic [34:0]        ucode_data,
  output logic [31:0]        control_signals,
  output logic               ctrl_valid,
  output logic [7:0]         imm8,
  output logic               busy,
  output logic               seq_err
);

  localparam int unsigned OPC_W  = UADDR_W - SLOT_W;
  localparam int unsigned CTRL_W = 32;
  localparam int unsigned IR_W   = 12;   // only low fields are ever used

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [UADDR_W-1:0]   upc_q, upc_d;
  logic [IR_W-1:0]      instr_reg_q, instr_reg_d;
  logic                 seq_err_q, seq_err_d;

  logic [OPC_W-1:0]     opcode;
  logic [UADDR_W-1:0]   disp_addr;
  logic                 uop_last;
  logic                 uop_sub_a;
  logic                 uop_sub_b;
  logic                 slot_end;
  logic                 accept;
  logic [CTRL_W-1:0]    ctrl_sub;

  assign opcode    = instr_data[INSTR_W-1 -: OPC_W];
  assign disp_addr = {opcode, {SLOT_W{1'b0}}};
  assign uop_last  = ucode_data[34];
  assign uop_sub_a = ucode_data[33];
  assign uop_sub_b = ucode_data[32];
  assign slot_end  = &upc_q[SLOT_W-1:0];

  // Next-state, micro-PC sequencing and same-cycle handshake outputs
  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    instr_reg_d = instr_reg_q;
    seq_err_d   = seq_err_q;
    instr_ready = 1'b0;
    ucode_en    = 1'b0;
    ucode_addr  = upc_q;
    ctrl_valid  = 1'b0;
    accept      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // rst_n gate keeps the handshake quiet while reset is held
        instr_ready = rst_n && !flush;
      end
      S_EXEC: begin
        ctrl_valid = !flush;
        if (flush) begin
          state_d = S_IDLE;
        end else if (!stall) begin
          if (uop_last) begin
            instr_ready = 1'b1;
            if (!instr_valid) state_d = S_IDLE;
          end else if (slot_end) begin
            // Sequence ran off the end of its slot: stop rather than wrap
            seq_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ucode_addr = upc_q + UADDR_W'(1);
            ucode_en   = 1'b1;
            upc_d      = upc_q + UADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Dispatch is identical from IDLE and from a chained last retire
    accept = instr_valid && instr_ready;
    if (accept) begin
      ucode_addr  = disp_addr;
      ucode_en    = 1'b1;
      upc_d       = disp_addr;
      instr_reg_d = instr_data[IR_W-1:0];
      state_d     = S_EXEC;
    end
  end

  // Register field substitution into the ROM control word
  always_comb begin
    ctrl_sub = ucode_data[CTRL_W-1:0];
    if (uop_sub_a) begin
      ctrl_sub[27:25] = instr_reg_q[11:9];
      ctrl_sub[16:14] = instr_reg_q[11:9];
    end
    if (uop_sub_b) begin
      ctrl_sub[24:22] = instr_reg_q[8:6];
      ctrl_sub[11:9]  = instr_reg_q[8:6];
    end
    control_signals = ctrl_valid ? ctrl_sub : '0;
  end

  assign imm8    = instr_reg_q[7:0];
  assign busy    = (state_q == S_EXEC);
  assign seq_err = seq_err_q;

  // State, micro-PC, instruction register and sticky overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      upc_q       <= '0;
      instr_reg_q <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      upc_q       <= upc_d;
      instr_reg_q <= instr_reg_d;
      seq_err_q   <= seq_err_d;
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer with a behavioural ROM and a
// scoreboard of expected control words popped on every retire.
module tb_ucode_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr_data;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        flush;
  logic [6:0]  ucode_addr;
  logic        ucode_en;
  logic [34:0] ucode_data;
  logic [31:0] control_signals;
  logic        ctrl_valid;
  logic [7:0]  imm8;
  logic        busy;
  logic        seq_err;

  logic [34:0] rom [128];
  logic [31:0] exp_q [$];
  int          n_cmp;
  int          n_err;

  ucode_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_data      (instr_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .stall           (stall),
    .flush           (flush),
    .ucode_addr      (ucode_addr),
    .ucode_en        (ucode_en),
    .ucode_data      (ucode_data),
    .control_signals (control_signals),
    .ctrl_valid      (ctrl_valid),
    .imm8            (imm8),
    .busy            (busy),
    .seq_err         (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: holds its output while not enabled
  initial ucode_data = '0;
  always @(posedge clk) if (ucode_en) ucode_data <= rom[ucode_addr];

  function automatic logic [31:0] exp_word(input logic [34:0] w, input logic [15:0] ir);
    logic [31:0] r;
    r = w[31:0];
    if (w[33]) begin r[27:25] = ir[11:9]; r[16:14] = ir[11:9]; end
    if (w[32]) begin r[24:22] = ir[8:6];  r[11:9]  = ir[8:6];  end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [6:0] base, input int n, input logic [15:0] ir);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_word(rom[base + 7'(i)], ir));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every retired micro-op must match the next expected word
  always @(negedge clk) begin
    if (rst_n && ctrl_valid && !stall) begin
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL retire_unexpected: observed %h expected none", control_signals);
      end
      if (exp_q.size() > 0) chk("retire_word", control_signals, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[7'h18] = {1'b1, 1'b1, 1'b0, 32'h0000_0000};
    rom[7'h10] = {1'b0, 1'b0, 1'b1, 32'h1111_0001};
    rom[7'h11] = {1'b0, 1'b1, 1'b1, 32'h2222_0002};
    rom[7'h12] = {1'b1, 1'b0, 1'b0, 32'h3333_0003};
    rom[7'h08] = {1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
    rom[7'h20] = {1'b0, 1'b1, 1'b0, 32'h4444_0004};
    rom[7'h21] = {1'b1, 1'b1, 1'b1, 32'h4545_0005};
    for (int i = 0; i < 8; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      rom[7'h28 + 7'(i)] = {1'b0, iv[0], iv[1], 32'h5000_0000 | iv};
    end

    // Reset state, with a valid instruction already presented
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    instr_data = 16'h3A80; instr_valid = 1'b1;
    #2;
    chk("rst_instr_ready", 32'(instr_ready), 0);
    chk("rst_ucode_en", 32'(ucode_en), 0);
    chk("rst_ctrl_valid", 32'(ctrl_valid), 0);
    chk("rst_control", control_signals, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_seq_err", 32'(seq_err), 0);
    chk("rst_imm8", 32'(imm8), 0);
    instr_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Single-op instruction with sub_a substitution
    instr_data = 16'h3A80; instr_valid = 1'b1; #1;
    chk("t1_ready", 32'(instr_ready), 1);
    chk("t1_addr", 32'(ucode_addr), 32'h18);
    chk("t1_en", 32'(ucode_en), 1);
    chk("t1_busy_pre", 32'(busy), 0);
    push_seq(7'h18, 1, 16'h3A80);
    tick(); instr_valid = 1'b0; #1;
    chk("t1_ctrl_valid", 32'(ctrl_valid), 1);
    chk("t1_control", control_signals, 32'h0A01_4000);
    chk("t1_imm8", 32'(imm8), 32'h80);
    chk("t1_last_ready", 32'(instr_ready), 1);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_idle", 32'(busy), 0);

    // Three-op sequence in slot 2, no stall
    instr_data = 16'h2E55; instr_valid = 1'b1; #1;
    chk("t2_addr0", 32'(ucode_addr), 32'h10);
    push_seq(7'h10, 3, 16'h2E55);
    tick(); instr_valid = 1'b0; #1;
    chk("t2_cv0", 32'(ctrl_valid), 1);
    chk("t2_addr1", 32'(ucode_addr), 32'h11);
    chk("t2_en1", 32'(ucode_en), 1);
    tick(); #1;
    chk("t2_cv1", 32'(ctrl_valid), 1);
    chk("t2_addr2", 32'(ucode_addr), 32'h12);
    tick(); #1;
    chk("t2_cv2", 32'(ctrl_valid), 1);
    chk("t2_en_last", 32'(ucode_en), 0);
    chk("t2_ready_last", 32'(instr_ready), 1);
    tick(); #1;
    chk("t2_idle", 32'(busy), 0);
    chk("t2_cv_idle", 32'(ctrl_valid), 0);

    // Four-cycle stall on the second micro-op
    instr_data = 16'h2C40; instr_valid = 1'b1; #1;
    push_seq(7'h10, 3, 16'h2C40);
    tick(); instr_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      stall = 1'b1; #1;
      chk("t3_stall_en", 32'(ucode_en), 0);
      chk("t3_stall_cv", 32'(ctrl_valid), 1);
      chk("t3_stall_ready", 32'(instr_ready), 0);
      chk("t3_stall_word", control_signals, exp_word(rom[7'h11], 16'h2C40));
      tick();
    end
    stall = 1'b0; #1;
    chk("t3_resume_addr", 32'(ucode_addr), 32'h12);
    chk("t3_resume_en", 32'(ucode_en), 1);
    tick(); tick(); #1;
    chk("t3_idle", 32'(busy), 0);

    // Zero-bubble chaining from a single-op instruction into slot 4
    instr_data = 16'h1340; instr_valid = 1'b1; #1;
    push_seq(7'h08, 1, 16'h1340);
    tick();
    instr_data = 16'h4BC0; instr_valid = 1'b1; #1;
    chk("t4_ready", 32'(instr_ready), 1);
    chk("t4_addr", 32'(ucode_addr), 32'h20);
    chk("t4_en", 32'(ucode_en), 1);
    chk("t4_cv_old", 32'(ctrl_valid), 1);
    push_seq(7'h20, 2, 16'h4BC0);
    tick(); instr_valid = 1'b0; #1;
    chk("t4_cv_new", 32'(ctrl_valid), 1);
    chk("t4_imm8", 32'(imm8), 32'hC0);
    chk("t4_addr1", 32'(ucode_addr), 32'h21);
    tick(); #1;
    chk("t4_last_ready", 32'(instr_ready), 1);
    tick(); #1;
    chk("t4_idle", 32'(busy), 0);

    // Flush during micro-op 1 of 3, then flush while idle
    instr_data = 16'h2E55; instr_valid = 1'b1; #1;
    tick(); instr_valid = 1'b0; flush = 1'b1; stall = 1'b1; #1;
    chk("t5_cv", 32'(ctrl_valid), 0);
    chk("t5_ready", 32'(instr_ready), 0);
    chk("t5_en", 32'(ucode_en), 0);
    chk("t5_control", control_signals, 0);
    tick(); flush = 1'b0; stall = 1'b0; #1;
    chk("t5_idle", 32'(busy), 0);
    chk("t5_ready_after", 32'(instr_ready), 1);
    flush = 1'b1; instr_data = 16'h3A80; instr_valid = 1'b1; #1;
    chk("t5_idle_flush_ready", 32'(instr_ready), 0);
    chk("t5_idle_flush_en", 32'(ucode_en), 0);
    tick(); flush = 1'b0; instr_valid = 1'b0; #1;
    chk("t5_still_idle", 32'(busy), 0);

    // Eight ops with no last marker: overrun, sticky error
    instr_data = 16'h5600; instr_valid = 1'b1; #1;
    push_seq(7'h28, 8, 16'h5600);
    tick(); instr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t6_cv", 32'(ctrl_valid), 1);
      if (i < 7) begin
        chk("t6_addr", 32'(ucode_addr), 32'h29 + 32'(i));
        chk("t6_en", 32'(ucode_en), 1);
      end else begin
        chk("t6_en_overrun", 32'(ucode_en), 0);
        chk("t6_err_before", 32'(seq_err), 0);
      end
      tick();
    end
    #1;
    chk("t6_seq_err", 32'(seq_err), 1);
    chk("t6_idle", 32'(busy), 0);
    chk("t6_cv_idle", 32'(ctrl_valid), 0);
    instr_data = 16'h3A80; instr_valid = 1'b1; #1;
    push_seq(7'h18, 1, 16'h3A80);
    tick(); instr_valid = 1'b0; #1;
    chk("t6_after_cv", 32'(ctrl_valid), 1);
    chk("t6_after_control", control_signals, 32'h0A01_4000);
    chk("t6_err_sticky", 32'(seq_err), 1);
    tick(); #1;

    // Reset asserted mid-sequence
    instr_data = 16'h2E55; instr_valid = 1'b1; #1;
    tick(); instr_valid = 1'b0; rst_n = 1'b0; #1;
    chk("t7_seq_err", 32'(seq_err), 0);
    chk("t7_cv", 32'(ctrl_valid), 0);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_control", control_signals, 0);
    tick(); rst_n = 1'b1;
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
